// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage data-memory interface for the RV32i pipeline.
// Issues one registered request per load/store, stalls the pipeline while the
// access is outstanding, abandons it after TIMEOUT silent cycles and returns
// the sign/zero-extended load word in the DONE cycle.

module mem_access_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_R_En_M,
    input  logic        MEM_W_En_M,
    input  logic [2:0]  Funct3_M,
    input  logic [31:0] ALU_Out_M,
    input  logic [31:0] Write_Data_M,
    output logic        DMEM_Req,
    output logic        DMEM_We,
    output logic [31:0] DMEM_Addr,
    output logic [31:0] DMEM_WData,
    output logic [3:0]  DMEM_Byte_En,
    input  logic        DMEM_Ack,
    input  logic [31:0] DMEM_RData,
    output logic [31:0] Data_Out_Ext_M,
    output logic        Stall_M,
    output logic        Misaligned_M,
    output logic        Bus_Err_M
);

    // Counter wide enough to hold TIMEOUT-1; the last BUSY cycle is at CNT_LAST.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      result_q;
    logic             err_q;
    logic [1:0]       off_q;
    logic [2:0]       funct3_q;

    logic        access_valid;
    logic        is_word;
    logic        is_half;
    logic        misaligned;
    logic        start;
    logic        timeout;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;

    // Decode the incoming access: width class, alignment and whether to launch it.
    always_comb begin
        access_valid = MEM_R_En_M | MEM_W_En_M;
        is_word      = Funct3_M[1];
        is_half      = ~Funct3_M[1] & Funct3_M[0];
        misaligned   = (is_word & (|ALU_Out_M[1:0])) | (is_half & ALU_Out_M[0]);
        start        = (state == IDLE) & access_valid & ~misaligned;
        timeout      = (state == BUSY) & ~DMEM_Ack & (wait_cnt == CNT_LAST);
    end

    // Lane enables and lane-replicated store data for the access being launched.
    always_comb begin
        be_next    = 4'b0000;
        wdata_next = Write_Data_M;
        if (is_word) begin
            be_next    = 4'b1111;
            wdata_next = Write_Data_M;
        end else if (is_half) begin
            be_next    = ALU_Out_M[1] ? 4'b1100 : 4'b0011;
            wdata_next = {2{Write_Data_M[15:0]}};
        end else begin
            be_next    = 4'b0001 << ALU_Out_M[1:0];
            wdata_next = {4{Write_Data_M[7:0]}};
        end
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        byte_sel = DMEM_RData[7:0];
        case (off_q)
            2'd0:    byte_sel = DMEM_RData[7:0];
            2'd1:    byte_sel = DMEM_RData[15:8];
            2'd2:    byte_sel = DMEM_RData[23:16];
            default: byte_sel = DMEM_RData[31:24];
        endcase
        half_sel = off_q[1] ? DMEM_RData[31:16] : DMEM_RData[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = DMEM_RData;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: launch from IDLE, finish on ack or timeout, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (DMEM_Ack || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus request registers, wait counter and captured result/error.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DMEM_Req     <= 1'b0;
            DMEM_We      <= 1'b0;
            DMEM_Addr    <= 32'd0;
            DMEM_WData   <= 32'd0;
            DMEM_Byte_En <= 4'd0;
            off_q        <= 2'd0;
            funct3_q     <= 3'd0;
            wait_cnt     <= '0;
            result_q     <= 32'd0;
            err_q        <= 1'b0;
        end else if (start) begin
            DMEM_Req     <= 1'b1;
            DMEM_We      <= MEM_W_En_M;
            DMEM_Addr    <= {ALU_Out_M[31:2], 2'b00};
            DMEM_WData   <= wdata_next;
            DMEM_Byte_En <= be_next;
            off_q        <= ALU_Out_M[1:0];
            funct3_q     <= Funct3_M;
            wait_cnt     <= '0;
            result_q     <= 32'd0;
            err_q        <= 1'b0;
        end else if (state == BUSY) begin
            if (DMEM_Ack) begin
                DMEM_Req <= 1'b0;
                result_q <= DMEM_We ? 32'd0 : load_ext;
                err_q    <= 1'b0;
            end else if (timeout) begin
                DMEM_Req <= 1'b0;
                result_q <= 32'd0;
                err_q    <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end
    end

    // Pipeline-facing outputs: stall while launching or waiting, results only in DONE.
    always_comb begin
        Stall_M        = start | (state == BUSY);
        Misaligned_M   = (state == IDLE) & access_valid & misaligned;
        Data_Out_Ext_M = (state == DONE) ? result_q : 32'd0;
        Bus_Err_M      = (state == DONE) & err_q;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed test-plan steps followed by randomized accesses,
// each checked against an arithmetic model of lanes, extension and timeout.

module tb_mem_access_unit;

    localparam int TIMEOUT = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_R_En_M;
    logic        MEM_W_En_M;
    logic [2:0]  Funct3_M;
    logic [31:0] ALU_Out_M;
    logic [31:0] Write_Data_M;
    logic        DMEM_Req;
    logic        DMEM_We;
    logic [31:0] DMEM_Addr;
    logic [31:0] DMEM_WData;
    logic [3:0]  DMEM_Byte_En;
    logic        DMEM_Ack;
    logic [31:0] DMEM_RData;
    logic [31:0] Data_Out_Ext_M;
    logic        Stall_M;
    logic        Misaligned_M;
    logic        Bus_Err_M;

    int checks   = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .MEM_R_En_M     (MEM_R_En_M),
        .MEM_W_En_M     (MEM_W_En_M),
        .Funct3_M       (Funct3_M),
        .ALU_Out_M      (ALU_Out_M),
        .Write_Data_M   (Write_Data_M),
        .DMEM_Req       (DMEM_Req),
        .DMEM_We        (DMEM_We),
        .DMEM_Addr      (DMEM_Addr),
        .DMEM_WData     (DMEM_WData),
        .DMEM_Byte_En   (DMEM_Byte_En),
        .DMEM_Ack       (DMEM_Ack),
        .DMEM_RData     (DMEM_RData),
        .Data_Out_Ext_M (Data_Out_Ext_M),
        .Stall_M        (Stall_M),
        .Misaligned_M   (Misaligned_M),
        .Bus_Err_M      (Bus_Err_M)
    );

    // Free-running 10-unit clock.
    always #5 CLK = ~CLK;

    // Absolute time limit so the run can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Number of bytes moved by an access of this funct3.
    function automatic int accessBytes(input logic [2:0] f3);
        if (f3[1]) return 4;
        else if (f3[0]) return 2;
        else return 1;
    endfunction

    function automatic bit modelMisaligned(input logic [2:0] f3, input logic [31:0] addr);
        return (int'(addr[1:0]) % accessBytes(f3)) != 0;
    endfunction

    function automatic logic [3:0] modelBe(input logic [2:0] f3, input logic [31:0] addr);
        int n;
        logic [3:0] m;
        n = accessBytes(f3);
        m = 4'((1 << n) - 1);
        return m << addr[1:0];
    endfunction

    function automatic logic [31:0] modelWdata(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        logic [31:0] r;
        n = accessBytes(f3);
        r = 32'd0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                              input logic [31:0] rd);
        int n;
        logic [63:0] v;
        logic [63:0] mask;
        n = accessBytes(f3);
        v = {32'd0, rd >> (8 * int'(addr[1:0]))};
        if (n < 4) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            v    = v & mask;
            if (!f3[2] && v[8*n-1]) v = v | ~mask;
        end
        return v[31:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One complete access: launch, watch every BUSY cycle, check the DONE cycle.
    // ackCycle is the 1-based BUSY cycle carrying DMEM_Ack; 0 or >TIMEOUT means never.
    task automatic applyStimulus(input logic re, input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd, input int ackCycle);
        bit          expMis;
        bit          expErr;
        logic [31:0] expRes;
        int          busy;
        bit          done;
        expMis = modelMisaligned(f3, addr);
        expErr = (ackCycle == 0) || (ackCycle > TIMEOUT);
        expRes = (expErr || we) ? 32'd0 : modelLoad(f3, addr, rd);

        @(posedge CLK);
        #1;
        MEM_R_En_M   = re;
        MEM_W_En_M   = we;
        Funct3_M     = f3;
        ALU_Out_M    = addr;
        Write_Data_M = wd;
        DMEM_Ack     = 1'b0;
        @(negedge CLK);
        if (expMis) begin
            checkOutput("misaligned_flag", 32'(Misaligned_M), 32'd1);
            checkOutput("misaligned_stall", 32'(Stall_M), 32'd0);
            checkOutput("misaligned_data", Data_Out_Ext_M, 32'd0);
            @(posedge CLK);
            #1;
            checkOutput("misaligned_req", 32'(DMEM_Req), 32'd0);
            MEM_R_En_M = 1'b0;
            MEM_W_En_M = 1'b0;
        end else begin
            checkOutput("c0_stall", 32'(Stall_M), 32'd1);
            checkOutput("c0_misaligned", 32'(Misaligned_M), 32'd0);
            checkOutput("c0_req", 32'(DMEM_Req), 32'd0);
            busy = 0;
            done = 1'b0;
            while (!done) begin
                @(posedge CLK);
                #1;
                busy++;
                checkOutput("busy_req", 32'(DMEM_Req), 32'd1);
                checkOutput("busy_stall", 32'(Stall_M), 32'd1);
                checkOutput("busy_data", Data_Out_Ext_M, 32'd0);
                if (busy == 1) begin
                    checkOutput("bus_we", 32'(DMEM_We), 32'(we));
                    checkOutput("bus_addr", DMEM_Addr, {addr[31:2], 2'b00});
                    checkOutput("bus_be", 32'(DMEM_Byte_En), 32'(modelBe(f3, addr)));
                    if (we) checkOutput("bus_wdata", DMEM_WData, modelWdata(f3, wd));
                end
                if (busy == ackCycle) begin
                    DMEM_Ack   = 1'b1;
                    DMEM_RData = rd;
                end else begin
                    DMEM_Ack   = 1'b0;
                    DMEM_RData = $urandom;
                end
                done = (busy == ackCycle) || (busy == TIMEOUT);
            end
            @(posedge CLK);
            #1;
            DMEM_Ack = 1'b0;
            checkOutput("done_req", 32'(DMEM_Req), 32'd0);
            checkOutput("done_stall", 32'(Stall_M), 32'd0);
            checkOutput("done_data", Data_Out_Ext_M, expRes);
            checkOutput("done_buserr", 32'(Bus_Err_M), 32'(expErr));
        end
    endtask

    logic [2:0] f3Table [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        int          sel;
        RST          = 1'b1;
        MEM_R_En_M   = 1'b0;
        MEM_W_En_M   = 1'b0;
        Funct3_M     = 3'd0;
        ALU_Out_M    = 32'd0;
        Write_Data_M = 32'd0;
        DMEM_Ack     = 1'b0;
        DMEM_RData   = 32'd0;
        #12;
        checkOutput("rst_req", 32'(DMEM_Req), 32'd0);
        checkOutput("rst_we", 32'(DMEM_We), 32'd0);
        checkOutput("rst_addr", DMEM_Addr, 32'd0);
        checkOutput("rst_wdata", DMEM_WData, 32'd0);
        checkOutput("rst_be", 32'(DMEM_Byte_En), 32'd0);
        checkOutput("rst_stall", 32'(Stall_M), 32'd0);
        checkOutput("rst_misaligned", 32'(Misaligned_M), 32'd0);
        checkOutput("rst_buserr", 32'(Bus_Err_M), 32'd0);
        checkOutput("rst_data", Data_Out_Ext_M, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        $display("[TB] directed test-plan accesses");
        applyStimulus(1, 0, 3'b010, 32'h0000_0100, 32'd0, 32'hDEAD_BEEF, 1);
        applyStimulus(1, 0, 3'b000, 32'h0000_0203, 32'd0, 32'h80FF_0102, 1);
        applyStimulus(1, 0, 3'b100, 32'h0000_0203, 32'd0, 32'h80FF_0102, 2);
        applyStimulus(1, 0, 3'b001, 32'h0000_0202, 32'd0, 32'h8001_1234, 1);
        applyStimulus(1, 0, 3'b101, 32'h0000_0200, 32'd0, 32'h8001_1234, 3);
        applyStimulus(0, 1, 3'b000, 32'h0000_1001, 32'h0000_00AB, 32'h1234_5678, 1);
        applyStimulus(0, 1, 3'b001, 32'h0000_1002, 32'h0000_CAFE, 32'h1234_5678, 2);
        applyStimulus(1, 1, 3'b010, 32'h0000_1004, 32'h5555_AAAA, 32'hFFFF_FFFF, 1);
        applyStimulus(1, 0, 3'b010, 32'h0000_0102, 32'd0, 32'd0, 1);
        applyStimulus(1, 0, 3'b010, 32'h0000_0400, 32'd0, 32'h1111_2222, 0);
        applyStimulus(1, 0, 3'b010, 32'h0000_0400, 32'd0, 32'h3333_4444, TIMEOUT);

        $display("[TB] reset during BUSY");
        @(posedge CLK);
        #1;
        MEM_R_En_M = 1'b1;
        MEM_W_En_M = 1'b0;
        Funct3_M   = 3'b010;
        ALU_Out_M  = 32'h0000_0300;
        @(posedge CLK);
        #1;
        checkOutput("rstbusy_req1", 32'(DMEM_Req), 32'd1);
        @(posedge CLK);
        #1;
        RST        = 1'b1;
        MEM_R_En_M = 1'b0;
        #1;
        checkOutput("rstbusy_req_drop", 32'(DMEM_Req), 32'd0);
        checkOutput("rstbusy_stall", 32'(Stall_M), 32'd0);
        @(posedge CLK);
        #1;
        RST        = 1'b0;
        DMEM_Ack   = 1'b1;
        DMEM_RData = 32'hBAD0_BAD0;
        @(posedge CLK);
        #1;
        DMEM_Ack = 1'b0;
        checkOutput("stray_req", 32'(DMEM_Req), 32'd0);
        checkOutput("stray_stall", 32'(Stall_M), 32'd0);
        checkOutput("stray_data", Data_Out_Ext_M, 32'd0);
        checkOutput("stray_buserr", 32'(Bus_Err_M), 32'd0);

        $display("[TB] randomized accesses");
        for (int k = 0; k < 40; k++) begin
            f   = f3Table[$urandom_range(0, 7)];
            a   = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                a = a & ~(32'(accessBytes(f)) - 32'd1);
            end
            sel = $urandom_range(1, 3);
            applyStimulus(sel[0], sel[1], f, a, $urandom, $urandom, $urandom_range(0, TIMEOUT + 1));
        end

        @(posedge CLK);
        #1;
        MEM_R_En_M = 1'b0;
        MEM_W_En_M = 1'b0;
        @(posedge CLK);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage data-memory interface for the RV32i pipeline. Consumes load/store control, address and store data from the execute-to-memory boundary. Drives a request/acknowledge data-memory bus with byte enables, holds the pipeline while an access is outstanding, and sign/zero-extends load data. Its `Data_Out_Ext_M` and `Bus_Err_M` feed the memory-to-writeback register.

## Interface
- `TIMEOUT`, default 16: maximum cycles in BUSY without `DMEM_Ack` before the access is abandoned; minimum 2.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `MEM_R_En_M` in 1: load in memory stage.
- `MEM_W_En_M` in 1: store in memory stage.
- `Funct3_M` in 3: access width/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `ALU_Out_M` in 32: byte address.
- `Write_Data_M` in 32: store source (rs2).
- `DMEM_Req` out 1: bus request, registered.
- `DMEM_We` out 1: 1 = write, registered.
- `DMEM_Addr` out 32: word address `{addr[31:2],2'b00}`, registered.
- `DMEM_WData` out 32: lane-replicated store data, registered.
- `DMEM_Byte_En` out 4: byte lane enables, registered.
- `DMEM_Ack` in 1: one-cycle completion pulse.
- `DMEM_RData` in 32: read word, valid with `DMEM_Ack`.
- `Data_Out_Ext_M` out 32: extended load result.
- `Stall_M` out 1: combinational; holds PC and all pipeline registers up to and including execute-to-memory.
- `Misaligned_M` out 1: combinational misaligned-access flag.
- `Bus_Err_M` out 1: access timed out.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE: on a valid aligned access, latch the request registers and go to BUSY.
  - BUSY: `DMEM_Req`=1 held. On `DMEM_Ack`, capture the extended read data (zero for a store) and go to DONE.
  - Timeout: if there is no ack and the wait counter equals `TIMEOUT-1`, set the error flag, capture 0 and go to DONE.
  - DONE: `DMEM_Req`=0. Unconditionally return to IDLE on the next edge.
- Valid access: `MEM_R_En_M | MEM_W_En_M`. If both are set, the store is performed and the read is ignored.
- Alignment rules:
  - Halfword (001/101) needs `addr[0]`=0.
  - Word (010, and 011/110/111, which are treated as word) needs `addr[1:0]`=0.
  - A misaligned access asserts `Misaligned_M` and issues no bus request. `Stall_M`=0, `Data_Out_Ext_M`=0, and the FSM stays in IDLE.
- Byte enables:
  - B: `4'b0001 << addr[1:0]`.
  - H: `addr[1]` ? 1100 : 0011.
  - W: 1111.
- Store data:
  - B: `{4{rs2[7:0]}}`.
  - H: `{2{rs2[15:0]}}`.
  - W: rs2.
- Load extraction uses the latched `addr[1:0]` and funct3. B/H are sign-extended; BU/HU are zero-extended.
- Wait counter: width `$clog2(TIMEOUT)`. Cleared on entry to BUSY; increments each BUSY cycle without ack.
- Ack and timeout in the same cycle: ack wins, no error.
- `DMEM_Ack` in IDLE or DONE is ignored.

## Timing
- Reset (async): state IDLE, counter 0, result register 0, error flag 0.
  - `DMEM_Req`/`DMEM_We`=0; `DMEM_Addr`/`DMEM_WData`=0; `DMEM_Byte_En`=0.
  - `Stall_M`=0, `Misaligned_M`=0, `Bus_Err_M`=0, `Data_Out_Ext_M`=0.
- Reset mid-BUSY drops `DMEM_Req` immediately. A later stray ack is ignored.
- `Stall_M` = (IDLE & valid & aligned) | BUSY. It is 0 in DONE, so the pipeline advances on the DONE edge and memory-to-writeback captures the result.
- Cycle 0 is the instruction entering M in IDLE.
  - Ack in the first BUSY cycle: BUSY in cycle 1, DONE in cycle 2. Latency is 3 cycles with 2 stall cycles.
  - Each additional wait cycle adds 1.
- `Data_Out_Ext_M` and `Bus_Err_M` carry the captured values only in DONE. Outside DONE they are 0, except that `Misaligned_M` is valid in IDLE.
- Worst case: `TIMEOUT` BUSY cycles, then DONE with `Bus_Err_M`=1.
- Back-to-back accesses: the next instruction enters M in the cycle after DONE, in IDLE, and starts a new cycle 0. The DONE-to-IDLE return costs no extra cycle.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF on the first BUSY cycle:
  - `DMEM_Addr`=0x100, BE=1111, `DMEM_Req` high for 1 cycle.
  - `Stall_M` high in cycles 0–1.
  - DONE in cycle 2 with `Data_Out_Ext_M`=0xDEADBEEF.
- LB at 0x203 and LBU at 0x203, word 0x80FF_0102 → 0xFFFFFF80 and 0x00000080 respectively.
- LH at 0x202 with word 0x8001_1234 → 0xFFFF8001. LHU at 0x200 → 0x00001234.
- SB, rs2=0x000000AB, addr 0x1001 → BE=0010, WData=0xABABABAB, `DMEM_We`=1, `Data_Out_Ext_M`=0.
- SH, addr 0x1002 → BE=1100.
- LW at 0x102 → `Misaligned_M`=1, `Stall_M`=0, `DMEM_Req` never asserted.
- With `TIMEOUT`=4 and no ack:
  - 4 BUSY cycles, then DONE with `Bus_Err_M`=1, data 0.
  - Repeat with ack on the 4th BUSY cycle → `Bus_Err_M`=0.
  - Assert `RST` in the 2nd BUSY cycle → `DMEM_Req`=0 immediately, IDLE, and a following ack has no effect.
